// File: rtl/counter_irq_ctrl_if.sv
// Load/enable/irq bundle between the irq controller, the counter it drives and the CPU status side.
// The controller uses the slave modport; whoever drives start/stop/ack/irq_in uses master.
interface counter_irq_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             start;
    logic             stop;
    logic             ack;
    logic             auto_reload;
    logic             irq_en;
    logic [WIDTH-1:0] reload_value;
    logic             irq_in;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             enable;
    logic             irq_pending;
    logic             irq_out;
    logic             overrun;
    logic [CNT_W-1:0] event_count;
    logic             busy;

    modport slave (
        input  start, stop, ack, auto_reload, irq_en, reload_value, irq_in,
        output load, load_value, enable, irq_pending, irq_out, overrun, event_count, busy
    );

    modport master (
        output start, stop, ack, auto_reload, irq_en, reload_value, irq_in,
        input  load, load_value, enable, irq_pending, irq_out, overrun, event_count, busy
    );
endinterface

// File: rtl/counter_irq_ctrl.sv
// Consumer of a counter's irq: edge-detects it, tracks pending/overrun/event count,
// and either auto-reloads the counter or parks it until software acks.
//
// state    | meaning
// IDLE     | counter disabled, waiting for start
// LOAD     | one-cycle load strobe with load_value
// RUN      | counter enabled, waiting for an irq edge
// WAIT_ACK | counter halted after an irq, waiting for ack
module counter_irq_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input logic                clk,
    input logic                rst_n,
    counter_irq_ctrl_if.slave  bus
);
    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_LOAD     = 2'd1;
    localparam logic [1:0] S_RUN      = 2'd2;
    localparam logic [1:0] S_WAIT_ACK = 2'd3;

    logic [1:0]       state, state_nxt;
    logic             irq_q;
    logic             irq_edge;
    logic             clear_stats;
    logic             pending_q, pending_nxt;
    logic             overrun_q, overrun_nxt;
    logic [CNT_W-1:0] count_q, count_nxt, count_base;
    logic [WIDTH-1:0] load_value_q;

    assign irq_edge    = bus.irq_in & ~irq_q;
    assign clear_stats = ~bus.stop & (state == S_IDLE) & bus.start;

    always_comb begin
        state_nxt = state;
        if (bus.stop) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:     if (bus.start) state_nxt = S_LOAD;
                S_LOAD:     state_nxt = S_RUN;
                S_RUN:      if (irq_edge) state_nxt = bus.auto_reload ? S_LOAD : S_WAIT_ACK;
                S_WAIT_ACK: if (bus.ack) state_nxt = S_LOAD;
                default:    state_nxt = S_IDLE;
            endcase
        end
    end

    // A start clears the statistics first; an edge in that same cycle is then counted fresh.
    always_comb begin
        count_base  = clear_stats ? '0 : count_q;
        count_nxt   = count_base;
        overrun_nxt = clear_stats ? 1'b0 : overrun_q;
        pending_nxt = pending_q;
        if (irq_edge) begin
            pending_nxt = 1'b1;
            if (!(&count_base))
                count_nxt = count_base + {{(CNT_W-1){1'b0}}, 1'b1};
            if (pending_q && !bus.ack)
                overrun_nxt = 1'b1;
        end else if (bus.ack) begin
            pending_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            irq_q        <= 1'b0;
            pending_q    <= 1'b0;
            overrun_q    <= 1'b0;
            count_q      <= '0;
            load_value_q <= '0;
        end else begin
            state     <= state_nxt;
            irq_q     <= bus.irq_in;
            pending_q <= pending_nxt;
            overrun_q <= overrun_nxt;
            count_q   <= count_nxt;
            // LOAD always exits to RUN, so every cycle headed for LOAD is a fresh entry.
            if (state_nxt == S_LOAD)
                load_value_q <= bus.reload_value;
        end
    end

    assign bus.load        = (state == S_LOAD);
    assign bus.enable      = (state == S_RUN);
    assign bus.busy        = (state != S_IDLE);
    assign bus.load_value  = load_value_q;
    assign bus.irq_pending = pending_q;
    assign bus.irq_out     = pending_q & bus.irq_en;
    assign bus.overrun     = overrun_q;
    assign bus.event_count = count_q;
endmodule
